// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state codes, the output width helper and the digit correction constant.
package bcd_to_bin_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t SHIFT = 2'd2;
    localparam state_t FIN   = 2'd3;

    localparam logic [3:0] BCD_CORR = 4'd3;

    // Bits needed to hold 10^digits - 1: 4, 7, 10, 14 for 1..4 digits.
    function automatic int bin_width(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_nibble_corr.sv
// Reverse double-dabble correction cell: a digit of 8 or more loses 3.
module bcd_nibble_corr
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd8) ? digit - BCD_CORR : digit;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with a
// Start/Busy/Done handshake: Start is taken only in IDLE, Done pulses once in FIN.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter  int DIGITS = 2,
    localparam int BIN_W  = bin_width(DIGITS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   BCD,
    output logic [BIN_W-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Err,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(BIN_W + 1);

    state_t              state;
    logic [4*DIGITS-1:0] digits;
    logic [BIN_W-1:0]    acc;
    logic [CW-1:0]       cnt;

    logic [4*DIGITS-1:0] shifted_digits;
    logic [4*DIGITS-1:0] corr_digits;
    logic [BIN_W-1:0]    shifted_acc;
    logic                bad_digit;

    // One right shift of the {digits, acc} pair: the digit LSB feeds the acc MSB.
    assign shifted_digits = digits >> 1;
    assign shifted_acc    = {digits[0], acc[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_corr
        bcd_nibble_corr u_corr (
            .digit (shifted_digits[4*g +: 4]),
            .fixed (corr_digits[4*g +: 4])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            digits <= '0;
            acc    <= '0;
            cnt    <= '0;
            Bin    <= '0;
            Err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        digits <= BCD;
                        acc    <= '0;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (bad_digit) begin
                        Err   <= 1'b1;
                        Bin   <= '0;
                        state <= FIN;
                    end else begin
                        Err   <= 1'b0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits <= corr_digits;
                    acc    <= shifted_acc;
                    cnt    <= cnt + 1'b1;
                    // Bin is published only once the last shift lands.
                    if (cnt == CW'(BIN_W - 1)) begin
                        Bin   <= shifted_acc;
                        state <= FIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state == LOAD) || (state == SHIFT);
    assign Done      = (state == FIN);
    assign dbg_state = state;

endmodule
